// File: rtl/top_core.sv
// Two-button logic block: synchronise + debounce in_1/in_0, apply op-selected boolean, register to out_0.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges from input change, 1 edge from op change; no backpressure.
module top_core #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_1,
  input  logic       in_0,
  input  logic [1:0] op,
  output logic       out_0,
  output logic       out_chg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [1:0]             synced;
  logic [1:0]             db_q;
  logic                   f;

  assign raw = {in_1, in_0};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      end
    end
  end

  // A change is accepted only after it has disagreed with db for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          db_q[i]  <= synced[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    f = 1'b0;
    case (op)
      2'b00:   f = db_q[1] & db_q[0];
      2'b01:   f = db_q[1] | db_q[0];
      2'b10:   f = db_q[1] ^ db_q[0];
      default: f = ~(db_q[1] & db_q[0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_0   <= 1'b0;
      out_chg <= 1'b0;
    end else begin
      out_0   <= f;
      out_chg <= (f != out_0);
    end
  end

endmodule

// File: tb/tb_top_core.sv
// Bench for top_core: truth-table vectors, hand-written timing sequences, and random stimulus vs a delay-line/window model.
module tb_top_core;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_1 = 1'b0;
  logic       in_0 = 1'b0;
  logic [1:0] op = 2'b00;
  logic       out_0;
  logic       out_chg;

  int total = 0;
  int bad   = 0;

  top_core #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_1(in_1), .in_0(in_0), .op(op),
    .out_0(out_0), .out_chg(out_chg)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples travel through a fixed delay line; a debounced
  // value flips once its last DEB synced samples all disagree with it.
  bit rq1[$], rq0[$];
  bit sh1[$], sh0[$];
  bit m_db1, m_db0, m_out, m_chg;

  function automatic bit fn(logic [1:0] o, bit a, bit b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return !(a & b);
    endcase
  endfunction

  function automatic bit all_differ(bit h[$], bit d);
    if (h.size() < DEB) return 1'b0;
    foreach (h[k]) if (h[k] == d) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(bit r, bit a, bit b, logic [1:0] o);
    bit s1, s0, f;
    if (r) begin
      rq1 = {}; rq0 = {}; sh1 = {}; sh0 = {};
      for (int k = 0; k < SYNC; k++) begin
        rq1.push_back(1'b0);
        rq0.push_back(1'b0);
      end
      m_db1 = 0; m_db0 = 0; m_out = 0; m_chg = 0;
    end else begin
      s1 = rq1.pop_front(); rq1.push_back(a);
      s0 = rq0.pop_front(); rq0.push_back(b);
      f = fn(o, m_db1, m_db0);
      m_chg = (f != m_out);
      m_out = f;
      sh1.push_back(s1); if (sh1.size() > DEB) void'(sh1.pop_front());
      sh0.push_back(s0); if (sh0.size() > DEB) void'(sh0.pop_front());
      if (all_differ(sh1, m_db1)) m_db1 = s1;
      if (all_differ(sh0, m_db0)) m_db0 = s0;
    end
  endtask

  task automatic chk(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(rst, in_1, in_0, op);
    #1;
    chk("model_out_0", out_0, m_out);
    chk("model_out_chg", out_chg, m_chg);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic       a;
    logic       b;
    logic       exp;
  } vec_t;

  vec_t vecs[16];
  int   hi_cnt;
  int   chg_cnt;
  int   hold;

  initial begin
    vecs[0]  = '{2'b00, 0, 0, 0}; vecs[1]  = '{2'b00, 1, 0, 0};
    vecs[2]  = '{2'b00, 0, 1, 0}; vecs[3]  = '{2'b00, 1, 1, 1};
    vecs[4]  = '{2'b01, 0, 0, 0}; vecs[5]  = '{2'b01, 1, 0, 1};
    vecs[6]  = '{2'b01, 0, 1, 1}; vecs[7]  = '{2'b01, 1, 1, 1};
    vecs[8]  = '{2'b10, 0, 0, 0}; vecs[9]  = '{2'b10, 1, 0, 1};
    vecs[10] = '{2'b10, 0, 1, 1}; vecs[11] = '{2'b10, 1, 1, 0};
    vecs[12] = '{2'b11, 0, 0, 1}; vecs[13] = '{2'b11, 1, 0, 1};
    vecs[14] = '{2'b11, 0, 1, 1}; vecs[15] = '{2'b11, 1, 1, 0};

    // Reset holds outputs low; with inputs low they stay low
    do_reset(3);
    chk("reset_out_0", out_0, 1'b0);
    chk("reset_out_chg", out_chg, 1'b0);
    run(10);
    chk("post_reset_out_0", out_0, 1'b0);

    // Truth table
    foreach (vecs[i]) begin
      op = vecs[i].op; in_1 = vecs[i].a; in_0 = vecs[i].b;
      run(10);
      chk($sformatf("truth_op%0d_%b%b", vecs[i].op, vecs[i].a, vecs[i].b), out_0, vecs[i].exp);
    end

    // Latency: both inputs rise just after edge 0; out_0 rises at edge 7
    op = 2'b00; in_1 = 0; in_0 = 0;
    run(10);
    in_1 = 1; in_0 = 1;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      chk($sformatf("latency_out_0_e%0d", e), out_0, (e >= 7));
      chk($sformatf("latency_chg_e%0d", e), out_chg, (e == 7));
    end

    // Glitch: 3-cycle pulse on in_0 is swallowed, 4-cycle pulse passes for 4 cycles
    in_1 = 1; in_0 = 0;
    run(12);
    in_0 = 1; run(3); in_0 = 0;
    for (int e = 0; e < 15; e++) begin
      cyc();
      chk("glitch3_out_0", out_0, 1'b0);
      chk("glitch3_chg", out_chg, 1'b0);
    end
    in_0 = 1; run(4); in_0 = 0;
    hi_cnt = 0; chg_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      cyc();
      if (out_0 === 1'b1) hi_cnt++;
      if (out_chg === 1'b1) chg_cnt++;
    end
    chk("pulse4_high_cycles", (hi_cnt == 4), 1'b1);
    chk("pulse4_chg_pulses", (chg_cnt == 2), 1'b1);

    // Op switch with settled inputs
    in_1 = 1; in_0 = 1; op = 2'b00;
    run(10);
    chk("opsw_before", out_0, 1'b1);
    op = 2'b10;
    cyc();
    chk("opsw_out_0", out_0, 1'b0);
    chk("opsw_chg", out_chg, 1'b1);
    cyc();
    chk("opsw_chg_clear", out_chg, 1'b0);

    // Reset mid-debounce at edge 5
    op = 2'b00; in_1 = 0; in_0 = 0;
    run(10);
    in_1 = 1; in_0 = 1;
    run(4);
    rst = 1'b1;
    cyc();
    chk("middeb_reset_out_0", out_0, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      chk($sformatf("middeb_out_0_e%0d", e), out_0, (e >= 7));
    end

    // First edge after reset with NAND selected
    in_1 = 0; in_0 = 0; op = 2'b11;
    do_reset(1);
    chk("nand_in_reset", out_0, 1'b0);
    cyc();
    chk("nand_first_out_0", out_0, 1'b1);
    chk("nand_first_chg", out_chg, 1'b1);
    cyc();
    chk("nand_chg_clear", out_chg, 1'b0);

    // Random stimulus against the model
    hold = 0;
    for (int e = 0; e < 600; e++) begin
      if (hold == 0) begin
        in_1 = 1'($urandom_range(0, 1));
        in_0 = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) op = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
